// File: rtl/ram_arbiter.sv
// Shares the single-port command RAM between the SPI command stream (requester 0) and
// the local host (requester 1); address/data pairs stay atomic and read data returns to its issuer.
module ram_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] req0_cmd,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [9:0] req1_cmd,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] rsp0_data,
    output logic       rsp0_valid,
    output logic [7:0] rsp1_data,
    output logic       rsp1_valid,
    output logic [9:0] ram_din,
    output logic       ram_rx_valid,
    input  logic [7:0] ram_dout,
    input  logic       ram_tx_valid,
    output logic       owner,
    output logic       busy,
    output logic       rd_timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOCKED, WAIT_RD} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_last;
    logic            r_owner;
    logic [CW-1:0]   r_cnt;
    logic [9:0]      r_ram_din;
    logic            r_ram_rx_valid;
    logic [7:0]      r_rsp0_data;
    logic [7:0]      r_rsp1_data;
    logic            r_rsp0_valid;
    logic            r_rsp1_valid;
    logic            r_rd_timeout;

    logic            w_grant;
    logic            w_accept;
    logic [9:0]      w_cmd;
    logic            w_rsp_fire;
    logic            w_timeout_fire;

    // Handshake: a command transfers on a rising edge where reqX_valid & reqX_ready;
    // ready is combinational, never depends on the other ready, and at most one is high.
    always_comb begin
        w_grant  = r_owner;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    w_grant  = ~r_last;
                    w_accept = 1'b1;
                end else if (req0_valid) begin
                    w_grant  = 1'b0;
                    w_accept = 1'b1;
                end else if (req1_valid) begin
                    w_grant  = 1'b1;
                    w_accept = 1'b1;
                end
            end
            LOCKED: begin
                w_grant  = r_owner;
                w_accept = r_owner ? req1_valid : req0_valid;
            end
            default: begin
                w_grant  = r_owner;
                w_accept = 1'b0;
            end
        endcase
    end

    assign w_cmd      = w_grant ? req1_cmd : req0_cmd;
    assign req0_ready = w_accept & ~w_grant;
    assign req1_ready = w_accept & w_grant;

    always_comb begin
        w_next         = r_state;
        w_rsp_fire     = 1'b0;
        w_timeout_fire = 1'b0;
        case (r_state)
            IDLE, LOCKED: begin
                if (w_accept) begin
                    case (w_cmd[9:8])
                        2'b01:   w_next = IDLE;
                        2'b11:   w_next = WAIT_RD;
                        default: w_next = LOCKED;
                    endcase
                end
            end
            WAIT_RD: begin
                // A response arriving on the timeout cycle still wins.
                if (ram_tx_valid) begin
                    w_rsp_fire = 1'b1;
                    w_next     = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout_fire = 1'b1;
                    w_next         = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_last         <= 1'b1;
            r_owner        <= 1'b0;
            r_cnt          <= '0;
            r_ram_din      <= '0;
            r_ram_rx_valid <= 1'b0;
            r_rsp0_data    <= '0;
            r_rsp1_data    <= '0;
            r_rsp0_valid   <= 1'b0;
            r_rsp1_valid   <= 1'b0;
            r_rd_timeout   <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_ram_rx_valid <= w_accept;
            r_rsp0_valid   <= w_rsp_fire & ~r_owner;
            r_rsp1_valid   <= w_rsp_fire & r_owner;
            r_rd_timeout   <= w_timeout_fire;
            if (w_accept) begin
                r_ram_din <= w_cmd;
                if (r_state == IDLE) r_last <= w_grant;
                if (w_cmd[9:8] != 2'b01) r_owner <= w_grant;
            end
            if (w_rsp_fire) begin
                if (r_owner) r_rsp1_data <= ram_dout;
                else         r_rsp0_data <= ram_dout;
            end
            // Held at zero outside WAIT_RD so every read starts from a cleared count.
            if (r_state != WAIT_RD)
                r_cnt <= '0;
            else if (!ram_tx_valid && r_cnt != CNT_LAST)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    assign ram_din      = r_ram_din;
    assign ram_rx_valid = r_ram_rx_valid;
    assign rsp0_data    = r_rsp0_data;
    assign rsp1_data    = r_rsp1_data;
    assign rsp0_valid   = r_rsp0_valid;
    assign rsp1_valid   = r_rsp1_valid;
    assign owner        = r_owner;
    assign busy         = (r_state != IDLE);
    assign rd_timeout   = r_rd_timeout;
endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter: a behavioural model predicts grants and
// responses into expected queues; a monitor pops them when the DUT strobes.
module tb_ram_arbiter;
    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] req0_cmd = '0;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [9:0] req1_cmd = '0;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [7:0] rsp0_data;
    logic       rsp0_valid;
    logic [7:0] rsp1_data;
    logic       rsp1_valid;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout = '0;
    logic       ram_tx_valid = 1'b0;
    logic       owner;
    logic       busy;
    logic       rd_timeout;

    ram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0_cmd(req0_cmd), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_cmd(req1_cmd), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .rsp0_data(rsp0_data), .rsp0_valid(rsp0_valid),
        .rsp1_data(rsp1_data), .rsp1_valid(rsp1_valid),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
        .owner(owner), .busy(busy), .rd_timeout(rd_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit started = 0;
    logic [9:0] exp_din_q[$];
    logic [9:0] exp_rsp_q[$];   // {kind, data}: kind 0 = rsp0, 1 = rsp1, 2 = timeout
    int acc_log[$];
    int n_rsp0 = 0, n_rsp1 = 0, n_to = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // RAM model: latency L puts ram_tx_valid L cycles after the read-data strobe; 0 = never.
    logic [7:0] mem [256];
    logic [7:0] ram_addr = '0;
    int ram_lat_cfg = 2;        // -1 picks a random latency per read
    int ram_pend = 0;
    int spur_cnt = 0;
    int spur_done = 0;

    initial for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    always @(posedge clk) begin
        #1;
        ram_tx_valid = 1'b0;
        if (rst) begin
            ram_pend = 0;
        end else begin
            if (ram_pend > 0) begin
                ram_pend--;
                if (ram_pend == 0) begin
                    ram_tx_valid = 1'b1;
                    ram_dout = mem[ram_addr];
                end
            end else if (spur_cnt != spur_done) begin
                ram_tx_valid = 1'b1;
                ram_dout = 8'($urandom);
                spur_done++;
            end
            if (ram_rx_valid) begin
                case (ram_din[9:8])
                    2'b00, 2'b10: ram_addr = ram_din[7:0];
                    2'b01:        mem[ram_addr] = ram_din[7:0];
                    default:      ram_pend = (ram_lat_cfg < 0) ? int'($urandom_range(0, 6)) : ram_lat_cfg;
                endcase
            end
        end
    end

    // Reference model: who holds the lock, whether a read is outstanding and for how long.
    bit m_lock = 0, m_wait = 0, m_owner = 0, m_last = 1;
    int m_cnt = 0;

    always @(negedge clk) begin
        logic e0, e1;
        logic [9:0] c;
        if (rst) begin
            m_lock = 0; m_wait = 0; m_owner = 0; m_last = 1; m_cnt = 0;
        end else begin
            e0 = 1'b0;
            e1 = 1'b0;
            if (!m_wait) begin
                if (m_lock) begin
                    if (m_owner) e1 = req1_valid; else e0 = req0_valid;
                end else if (req0_valid && (!req1_valid || m_last)) begin
                    e0 = 1'b1;
                end else begin
                    e1 = req1_valid;
                end
            end
            if (started) begin
                chk("req0_ready", req0_ready, e0);
                chk("req1_ready", req1_ready, e1);
                chk("busy", busy, m_lock | m_wait);
                chk("owner", owner, m_owner);
            end
            if (e0 || e1) begin
                c = e1 ? req1_cmd : req0_cmd;
                exp_din_q.push_back(c);
                if (!m_lock) m_last = e1;
                case (c[9:8])
                    2'b01: m_lock = 0;
                    2'b11: begin m_lock = 0; m_wait = 1; m_owner = e1; m_cnt = 0; end
                    default: begin m_lock = 1; m_owner = e1; end
                endcase
            end else if (m_wait) begin
                if (ram_tx_valid) begin
                    exp_rsp_q.push_back({1'b0, m_owner, ram_dout});
                    m_wait = 0;
                end else if (m_cnt == TIMEOUT - 1) begin
                    exp_rsp_q.push_back({2'd2, 8'h00});
                    m_wait = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT strobes an output.
    logic [7:0] hold0 = '0, hold1 = '0;

    always @(negedge clk) begin
        logic [9:0] a, e;
        if (started) begin
            if (!rst && req0_valid && req0_ready) acc_log.push_back(0);
            if (!rst && req1_valid && req1_ready) acc_log.push_back(1);
            if (ram_rx_valid) begin
                if (exp_din_q.size() == 0) chk("ram_rx_valid_unexpected", ram_rx_valid, 0);
                else chk("ram_din", ram_din, exp_din_q.pop_front());
            end
            if (rsp0_valid || rsp1_valid || rd_timeout) begin
                chk("rsp_onehot", 32'(rsp0_valid) + 32'(rsp1_valid) + 32'(rd_timeout), 1);
                a = rd_timeout ? {2'd2, 8'h00} : (rsp1_valid ? {2'd1, rsp1_data} : {2'd0, rsp0_data});
                if (rsp0_valid) n_rsp0++;
                if (rsp1_valid) n_rsp1++;
                if (rd_timeout) n_to++;
                if (exp_rsp_q.size() == 0) begin
                    chk("rsp_unexpected", {rsp0_valid, rsp1_valid, rd_timeout}, 0);
                end else begin
                    e = exp_rsp_q.pop_front();
                    chk("rsp_event", a, e);
                    if (e[9:8] == 2'd0) hold0 = e[7:0];
                    if (e[9:8] == 2'd1) hold1 = e[7:0];
                end
            end
            chk("rsp0_data_hold", rsp0_data, hold0);
            chk("rsp1_data_hold", rsp1_data, hold1);
        end
        if (rst) begin
            hold0 = '0;
            hold1 = '0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input logic [9:0] cmd);
        bit done = 0;
        int n = 0;
        if (r == 0) begin req0_cmd = cmd; req0_valid = 1'b1; end
        else        begin req1_cmd = cmd; req1_valid = 1'b1; end
        while (!done) begin
            @(negedge clk);
            done = (r == 0) ? (req0_ready === 1'b1) : (req1_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
            if (!done && n >= 200) begin
                chk("accept_wait", done, 1);
                done = 1;
            end
        end
        if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_ram_din", ram_din, 0);
        chk("rst_ram_rx_valid", ram_rx_valid, 0);
        chk("rst_rsp0_data", rsp0_data, 0);
        chk("rst_rsp1_data", rsp1_data, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_timeout", rd_timeout, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic stream(input int r, input int n);
        int kind;
        logic [7:0] p;
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 4);
            p = 8'($urandom);
            case (kind)
                0: begin send(r, {2'b00, p}); send(r, {2'b01, 8'($urandom)}); end
                1: begin send(r, {2'b10, p}); send(r, {2'b11, 8'h00}); end
                2: send(r, {2'b01, p});
                3: send(r, {2'b11, 8'h00});
                default: begin send(r, {2'b00, p}); send(r, {2'b10, 8'($urandom)}); send(r, {2'b11, 8'h00}); end
            endcase
            tick($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) spur_cnt++;
        end
    endtask

    initial begin
        int b0, b1, bt;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1;
        @(negedge clk);
        check_reset_values();
        tick(1);

        // Write then read on requester 0; the RAM answers two cycles after the strobe.
        ram_lat_cfg = 2;
        b0 = n_rsp0; b1 = n_rsp1;
        send(0, 10'h005); send(0, 10'h1A5); send(0, 10'h205); send(0, 10'h300);
        tick(8);
        chk("t1_rsp0_count", n_rsp0 - b0, 1);
        chk("t1_rsp0_data", rsp0_data, 8'hA5);
        chk("t1_rsp1_count", n_rsp1 - b1, 0);

        // Simultaneous requests after reset alternate starting with requester 0.
        pulse_reset();
        acc_log.delete();
        req0_cmd = 10'h111; req1_cmd = 10'h122;
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick(4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(1);
        chk("t2_accepts", acc_log.size(), 4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) chk("t2_order", acc_log[i], i % 2);

        // Requester 1 holds the lock; requester 0 waits until after its read response.
        acc_log.delete();
        b1 = n_rsp1;
        send(1, 10'h210);
        fork
            send(0, 10'h001);
            begin tick(6); send(1, 10'h300); end
        join
        tick(2);
        chk("t3_accepts", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            chk("t3_first", acc_log[0], 1);
            chk("t3_second", acc_log[1], 1);
            chk("t3_third", acc_log[2], 0);
        end
        chk("t3_rsp1_count", n_rsp1 - b1, 1);

        // Read with no RAM answer: timeout fires on the fourth waiting cycle.
        ram_lat_cfg = 0;
        b0 = n_rsp0; b1 = n_rsp1; bt = n_to;
        send(0, 10'h005);
        send(0, 10'h300);
        tick(3);
        chk("t4_busy_waiting", busy, 1);
        chk("t4_no_early_timeout", rd_timeout, 0);
        tick(1);
        chk("t4_timeout_pulse", rd_timeout, 1);
        chk("t4_busy_after", busy, 0);
        tick(1);
        chk("t4_timeout_one_cycle", rd_timeout, 0);
        spur_cnt++;
        tick(4);
        chk("t4_timeout_count", n_to - bt, 1);
        chk("t4_rsp0_count", n_rsp0 - b0, 0);
        chk("t4_rsp1_count", n_rsp1 - b1, 0);

        // Reset while waiting for read data drops the read silently.
        b0 = n_rsp0; b1 = n_rsp1; bt = n_to;
        send(0, 10'h300);
        pulse_reset();
        check_reset_values();
        tick(6);
        chk("t5_rsp_count", (n_rsp0 - b0) + (n_rsp1 - b1), 0);
        chk("t5_timeout_count", n_to - bt, 0);
        acc_log.delete();
        req0_cmd = 10'h133; req1_cmd = 10'h144;
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick(1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(1);
        chk("t5_tie_accepts", acc_log.size(), 1);
        if (acc_log.size() == 1) chk("t5_tie_winner", acc_log[0], 0);

        // Random concurrent traffic with random RAM latency, including no-answer reads.
        ram_lat_cfg = -1;
        fork
            stream(0, 40);
            stream(1, 40);
        join
        tick(20);
        chk("din_queue_drained", exp_din_q.size(), 0);
        chk("rsp_queue_drained", exp_rsp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port command RAM between two command sources: the SPI slave command stream and a local host port. It forwards 10-bit command words to the RAM and keeps each address/data pair atomic per requester. It returns read data only to the requester that issued the read, and bounds the read wait with a timeout. It sits between both requesters and the RAM's `din`/`rx_valid`/`dout`/`tx_valid` pins.

## Interface
- `TIMEOUT`, 15: max cycles spent in WAIT_RD waiting for `ram_tx_valid`; legal range 1–255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_cmd` in 10: requester 0 (SPI) command word.
- `req0_valid` in 1: requester 0 command present.
- `req0_ready` out 1: requester 0 command accepted this cycle; combinational.
- `req1_cmd` in 10: requester 1 (host) command word.
- `req1_valid` in 1: requester 1 command present.
- `req1_ready` out 1: requester 1 command accepted this cycle; combinational.
- `rsp0_data` out 8: read data for requester 0.
- `rsp0_valid` out 1: one-cycle strobe qualifying `rsp0_data`.
- `rsp1_data` out 8: read data for requester 1.
- `rsp1_valid` out 1: one-cycle strobe qualifying `rsp1_data`.
- `ram_din` out 10: command word to the RAM.
- `ram_rx_valid` out 1: one-cycle strobe qualifying `ram_din`.
- `ram_dout` in 8: RAM read data.
- `ram_tx_valid` in 1: RAM read data valid.
- `owner` out 1: requester currently holding the lock or read; holds its last value in IDLE.
- `busy` out 1: high when state is LOCKED or WAIT_RD.
- `rd_timeout` out 1: one-cycle pulse when a read is abandoned.

## Operation
- Command word fields:
  - `[9:8]` opcode: 00 = write-address, 01 = write-data, 10 = read-address, 11 = read-data.
  - `[7:0]` payload.
- A command is accepted on an edge where `reqX_valid & reqX_ready` is high. At most one command is accepted per cycle.
- An accepted command is registered to `ram_din`, and `ram_rx_valid` is driven high for exactly one cycle.
- States: IDLE, LOCKED, WAIT_RD.
- IDLE:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted most recently wins (round-robin pointer `last`, updated on every IDLE accept).
  - Exactly one `ready` is high, and only when its own `valid` is high.
  - Opcode 00 or 10: go to LOCKED, `owner` = granted requester.
  - Opcode 01: stay in IDLE; a standalone data write uses the RAM's held address.
  - Opcode 11: go to WAIT_RD, `owner` = granted requester.
- LOCKED:
  - Only `owner`'s `ready` may be high; the other requester's `ready` stays 0 for as long as the state lasts, with no timeout on the lock.
  - Owner opcode 00 or 10: forwarded, stay in LOCKED (re-address).
  - Owner opcode 01: forwarded, go to IDLE.
  - Owner opcode 11: forwarded, go to WAIT_RD.
- WAIT_RD:
  - Both `ready` outputs are 0.
  - The wait counter clears on entry and increments each cycle in which `ram_tx_valid` is 0.
  - If `ram_tx_valid` = 1: capture `ram_dout` into `rsp<owner>_data`, pulse `rsp<owner>_valid` for one cycle, go to IDLE.
  - If the counter equals TIMEOUT−1 and `ram_tx_valid` = 0: pulse `rd_timeout`, no response strobe, go to IDLE.
  - If `ram_tx_valid` arrives in the same cycle the timeout would fire, the response wins and there is no `rd_timeout`.
- `ram_tx_valid` outside WAIT_RD is ignored; no `rsp` strobe is produced.
- The `rsp*_data` registers hold their last value between strobes.
- Counter width is $clog2(TIMEOUT+1) bits; it never wraps.

## Timing
- Reset values:
  - State = IDLE, `last` = 1 (so requester 0 wins the first tie), counter = 0.
  - `ram_din` = 0, `ram_rx_valid` = 0.
  - `rsp0_data` = `rsp1_data` = 0, `rsp0_valid` = `rsp1_valid` = 0.
  - `owner` = 0, `busy` = 0, `rd_timeout` = 0.
- Accept at edge N → `ram_rx_valid` high during cycle N+1 (one-cycle latency).
- Data command accepted at edge N → state and `busy` change at edge N.
- `ram_tx_valid` high in cycle M → `rsp_valid` high in cycle M+1. The state is IDLE from edge M, so a new command can be accepted in cycle M+1.
- Back-to-back accepts in consecutive cycles are legal in IDLE and LOCKED.
- Reset asserted mid-transaction (LOCKED or WAIT_RD) → IDLE at the next edge. The pending read is dropped with no `rsp` strobe and no `rd_timeout`.

## Test plan
- Write then read, same requester:
  - Stimulus: req0 sends 0x0_05, 0x1_A5, 0x2_05, 0x3_00; RAM model returns 0xA5 two cycles after the 0x3_00 strobe.
  - Required: `ram_din` sequence 0x005, 0x1A5, 0x205, 0x300, each with one `ram_rx_valid` cycle; `rsp0_valid` pulses once with `rsp0_data` = 0xA5; `rsp1_valid` never pulses.
- Simultaneous IDLE requests after reset:
  - Stimulus: req0 and req1 both hold 0x1_11 (req0) and 0x1_22 (req1) valid continuously.
  - Required: accept order req0, req1, req0, req1 (strict alternation).
- Lock enforcement:
  - Stimulus: req1 sends 0x2_10; req0 is then held valid with 0x0_01 for 10 cycles; req1 sends 0x3_00 after 6 cycles.
  - Required: `req0_ready` = 0 throughout LOCKED and WAIT_RD; req0 is accepted only after req1's response.
- Read timeout:
  - Stimulus: TIMEOUT = 4; req0 read sequence with the RAM never asserting `ram_tx_valid`.
  - Required: `rd_timeout` pulses once, 4 cycles after WAIT_RD entry; no `rsp0_valid`; `busy` = 0 after; a late `ram_tx_valid` is ignored.
- Reset during WAIT_RD:
  - Stimulus: `rst` = 1 for one cycle, 1 cycle after a 0x3_00 accept.
  - Required: all outputs return to reset values; no `rsp` strobe; next tie goes to req0.
